rx_det_seq: RTL

- Sequences the per-lane receiver-detect handshake for core_fsm during Detect.Active.
- The detect circuit is shared, so lanes are probed one at a time in ascending order over a 4-phase req/ack handshake, with ack timeout and inter-lane settle time.
- Runs up to MAX_PASS passes when only a subset of lanes detects.
- Reports the final detected-lane mask (AND of all passes) and per-lane timeout flags.

---
 rtl/rx_det_seq_if.sv | 21 ++
 rtl/rx_det_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rx_det_seq_if.sv
// Probe handshake between the receiver-detect sequencer and the shared
// lane detect circuit: one-hot request out, per-lane ack and result back.
interface rx_det_seq_if #(
    parameter int NUM_LANES = 4
) ();
    logic [NUM_LANES-1:0] rx_det_seq_req;
    logic [NUM_LANES-1:0] rx_det_seq_ack;
    logic [NUM_LANES-1:0] lane_rx_det;

    modport master (
        output rx_det_seq_req,
        input  rx_det_seq_ack,
        input  lane_rx_det
    );

    modport slave (
        input  rx_det_seq_req,
        output rx_det_seq_ack,
        output lane_rx_det
    );
endinterface

// File: rtl/rx_det_seq.sv
// Receiver-detect sequencer: probes lanes one at a time over a 4-phase
// req/ack handshake, with ack timeout and settle gap, repeating the sweep
// up to MAX_PASS times while only a subset of lanes detects. The final
// mask is the AND of all passes.
module rx_det_seq #(
    parameter int NUM_LANES   = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int SETTLE_CYC  = 16,
    parameter int MAX_PASS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,          // asynchronous, active-low
    input  logic                 start,
    input  logic                 abort,
    rx_det_seq_if.master         bus,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_LANES-1:0] det_mask,
    output logic [NUM_LANES-1:0] timeout_err
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PASS_W = $clog2(MAX_PASS + 1);
    localparam int TMO_W  = $clog2(ACK_TIMEOUT) + 1;
    localparam int SET_W  = $clog2(SETTLE_CYC) + 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
    localparam logic [PASS_W-1:0] PASS_MAX  = PASS_W'(MAX_PASS);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        DROP,
        SETTLE,
        PASS_END,
        DONE
    } state_e;

    state_e               state_q,       state_d;
    logic [LANE_W-1:0]    lane_q,        lane_d;
    logic [PASS_W-1:0]    pass_q,        pass_d;
    logic [NUM_LANES-1:0] pass_mask_q,   pass_mask_d;
    logic [NUM_LANES-1:0] acc_mask_q,    acc_mask_d;
    logic [NUM_LANES-1:0] det_mask_q,    det_mask_d;
    logic [NUM_LANES-1:0] timeout_err_q, timeout_err_d;
    logic [NUM_LANES-1:0] req_q,         req_d;
    logic [TMO_W-1:0]     tmo_cnt_q,     tmo_cnt_d;
    logic [SET_W-1:0]     settle_cnt_q,  settle_cnt_d;
    logic                 busy_q,        busy_d;
    logic                 done_q,        done_d;

    // Next-state, per-lane capture and registered-output decode.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d       = state_q;
        lane_d        = lane_q;
        pass_d        = pass_q;
        pass_mask_d   = pass_mask_q;
        acc_mask_d    = acc_mask_q;
        det_mask_d    = det_mask_q;
        timeout_err_d = timeout_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        settle_cnt_d  = settle_cnt_q;

        if (abort && (state_q != IDLE)) begin
            // Abort wins over everything: partial timeout flags and the
            // previous det_mask are left as they are.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d       = REQ;
                        lane_d        = '0;
                        pass_d        = PASS_W'(1);
                        pass_mask_d   = '0;
                        timeout_err_d = '0;
                    end
                end

                REQ: begin
                    tmo_cnt_d = '0;
                    state_d   = WAIT_ACK;
                end

                WAIT_ACK: begin
                    // An ack already high on entry counts on the first sample.
                    if (bus.rx_det_seq_ack[lane_q]) begin
                        pass_mask_d[lane_q] = bus.lane_rx_det[lane_q];
                        state_d             = DROP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        pass_mask_d[lane_q]   = 1'b0;
                        timeout_err_d[lane_q] = 1'b1;
                        settle_cnt_d          = '0;
                        state_d               = SETTLE;
                    end else if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end

                DROP: begin
                    if (!bus.rx_det_seq_ack[lane_q]) begin
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_cnt_q == SET_LAST) begin
                        if (lane_q < LANE_LAST) begin
                            lane_d  = lane_q + LANE_W'(1);
                            state_d = REQ;
                        end else begin
                            state_d = PASS_END;
                        end
                    end else if (settle_cnt_q != '1) begin
                        settle_cnt_d = settle_cnt_q + SET_W'(1);
                    end
                end

                PASS_END: begin
                    acc_mask_d = (pass_q == PASS_W'(1)) ? pass_mask_q
                                                        : (acc_mask_q & pass_mask_q);
                    // Another sweep only helps when some, but not all, lanes
                    // were seen and passes remain.
                    if ((acc_mask_d != '0) && (acc_mask_d != '1) && (pass_q < PASS_MAX)) begin
                        pass_d      = pass_q + PASS_W'(1);
                        lane_d      = '0;
                        pass_mask_d = '0;
                        state_d     = REQ;
                    end else begin
                        // Published on entry so det_mask is valid with done.
                        det_mask_d = acc_mask_d;
                        state_d    = DONE;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they come straight
        // from flops: req is high in REQ and WAIT_ACK for the current lane.
        req_d  = ((state_d == REQ) || (state_d == WAIT_ACK)) ? (NUM_LANES'(1) << lane_d) : '0;
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            pass_q        <= '0;
            pass_mask_q   <= '0;
            acc_mask_q    <= '0;
            det_mask_q    <= '0;
            timeout_err_q <= '0;
            req_q         <= '0;
            tmo_cnt_q     <= '0;
            settle_cnt_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            lane_q        <= lane_d;
            pass_q        <= pass_d;
            pass_mask_q   <= pass_mask_d;
            acc_mask_q    <= acc_mask_d;
            det_mask_q    <= det_mask_d;
            timeout_err_q <= timeout_err_d;
            req_q         <= req_d;
            tmo_cnt_q     <= tmo_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.rx_det_seq_req = req_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign det_mask           = det_mask_q;
    assign timeout_err        = timeout_err_q;

endmodule
